// File: rtl/rst_button_cond.sv
// Reset-input conditioner for the i8284 RESN pin: synchronises and debounces the board
// button, then stretches power-on and button resets into clean active-low requests.
module rst_button_cond #(
    parameter int DIV       = 4096,
    parameter int DEB_N     = 16,
    parameter int MIN_LOW   = 64,
    parameter int POR_TICKS = 256
) (
    input  logic CLK,
    input  logic RESN,
    input  logic BUT_IN,
    output logic RESN_OUT,
    output logic BUT_STATE,
    output logic PRESS,
    output logic TICK
);

    localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DW   = $clog2(DEB_N + 1);
    localparam int TMAX = (POR_TICKS > MIN_LOW) ? POR_TICKS : MIN_LOW;
    localparam int TW   = $clog2(TMAX + 1);

    if (DIV < 2 || DEB_N < 1 || MIN_LOW < 1 || POR_TICKS < 1) begin : g_param_check
        $error("rst_button_cond: illegal parameters (need DIV>=2, DEB_N>=1, MIN_LOW>=1, POR_TICKS>=1)");
    end

    typedef enum logic [1:0] {
        S_POR,
        S_IDLE,
        S_ASSERT,
        S_HOLD
    } state_t;

    logic          sync1_q, sync2_q;
    logic [PW-1:0] presc_q, presc_d;
    logic [DW-1:0] debCnt_q, debCnt_d;
    logic          butState_q, butState_d;
    logic          press_q, press_d;
    logic          resnOut_q;
    logic [TW-1:0] tickCnt_q;
    state_t        state_q;
    logic          tick;

    assign tick = (presc_q == PW'(DIV - 1));

    always_comb begin
        presc_d    = tick ? '0 : presc_q + PW'(1);
        debCnt_d   = debCnt_q;
        butState_d = butState_q;
        press_d    = 1'b0;
        if (tick) begin
            if (sync2_q == butState_q) begin
                debCnt_d = '0;
            end else if (debCnt_q == DW'(DEB_N - 1)) begin
                debCnt_d   = '0;
                butState_d = ~butState_q;
                press_d    = butState_q;
            end else begin
                debCnt_d = debCnt_q + DW'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RESN) begin
        if (!RESN) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            presc_q    <= '0;
            debCnt_q   <= '0;
            butState_q <= 1'b1;
            press_q    <= 1'b0;
        end else begin
            sync1_q    <= BUT_IN;
            sync2_q    <= sync1_q;
            presc_q    <= presc_d;
            debCnt_q   <= debCnt_d;
            butState_q <= butState_d;
            press_q    <= press_d;
        end
    end

    // The FSM deliberately looks at the pre-edge debounced level, so a flip and a
    // transition landing on the same tick edge are both taken independently.
    always_ff @(posedge CLK or negedge RESN) begin
        if (!RESN) begin
            state_q   <= S_POR;
            tickCnt_q <= '0;
            resnOut_q <= 1'b0;
        end else begin
            case (state_q)
                S_POR: begin
                    if (tick) begin
                        if (tickCnt_q == TW'(POR_TICKS - 1)) begin
                            tickCnt_q <= '0;
                            if (butState_q) begin
                                state_q   <= S_IDLE;
                                resnOut_q <= 1'b1;
                            end else begin
                                state_q <= S_HOLD;
                            end
                        end else begin
                            tickCnt_q <= tickCnt_q + TW'(1);
                        end
                    end
                end
                S_IDLE: begin
                    if (!butState_q) begin
                        state_q   <= S_ASSERT;
                        tickCnt_q <= '0;
                        resnOut_q <= 1'b0;
                    end
                end
                S_ASSERT: begin
                    if (tick) begin
                        if (tickCnt_q == TW'(MIN_LOW - 1)) begin
                            tickCnt_q <= '0;
                            if (butState_q) begin
                                state_q   <= S_IDLE;
                                resnOut_q <= 1'b1;
                            end else begin
                                state_q <= S_HOLD;
                            end
                        end else begin
                            tickCnt_q <= tickCnt_q + TW'(1);
                        end
                    end
                end
                S_HOLD: begin
                    if (butState_q) begin
                        state_q   <= S_IDLE;
                        tickCnt_q <= '0;
                        resnOut_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= S_POR;
                    tickCnt_q <= '0;
                    resnOut_q <= 1'b0;
                end
            endcase
        end
    end

    assign RESN_OUT  = resnOut_q;
    assign BUT_STATE = butState_q;
    assign PRESS     = press_q;
    assign TICK      = tick;

endmodule

// File: tb/tb_rst_button_cond.sv
// Bench for rst_button_cond: directed reset/press scenarios followed by random button
// activity, all checked cycle by cycle against a countdown-style behavioural model.
module tb_rst_button_cond;

    localparam int DIV       = 4;
    localparam int DEB_N     = 3;
    localparam int MIN_LOW   = 5;
    localparam int POR_TICKS = 8;

    logic CLK;
    logic RESN;
    logic BUT_IN;
    logic RESN_OUT;
    logic BUT_STATE;
    logic PRESS;
    logic TICK;

    int assertCount = 0;
    int failCount   = 0;
    int pressCount  = 0;

    // Model state: edges since reset release, queued synchroniser samples, run length of
    // differing tick samples, remaining low ticks of a reset pulse, and a wait-for-release flag.
    int   mEdges;
    logic mSyncQ[$];
    int   mRun;
    logic mBut;
    logic mPress;
    logic mResnOut;
    int   mLowLeft;
    bit   mHolding;

    rst_button_cond #(
        .DIV      (DIV),
        .DEB_N    (DEB_N),
        .MIN_LOW  (MIN_LOW),
        .POR_TICKS(POR_TICKS)
    ) dut (
        .CLK      (CLK),
        .RESN     (RESN),
        .BUT_IN   (BUT_IN),
        .RESN_OUT (RESN_OUT),
        .BUT_STATE(BUT_STATE),
        .PRESS    (PRESS),
        .TICK     (TICK)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        assertCount++;
        if (observed != expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d at time %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mEdges   = 0;
        mSyncQ   = {1'b1, 1'b1};
        mRun     = 0;
        mBut     = 1'b1;
        mPress   = 1'b0;
        mResnOut = 1'b0;
        mLowLeft = POR_TICKS;
        mHolding = 1'b0;
    endtask

    task automatic modelEdge(input logic butIn);
        logic preBut;
        logic sample;
        bit   tickNow;
        preBut  = mBut;
        tickNow = (mEdges % DIV) == DIV - 1;
        sample  = mSyncQ.pop_front();
        mSyncQ.push_back(butIn);
        mPress  = 1'b0;
        if (tickNow) begin
            if (sample != preBut) begin
                mRun++;
                if (mRun == DEB_N) begin
                    mBut   = ~preBut;
                    mRun   = 0;
                    mPress = preBut;
                end
            end else begin
                mRun = 0;
            end
        end
        if (mLowLeft > 0) begin
            if (tickNow) begin
                mLowLeft--;
                if (mLowLeft == 0) begin
                    if (preBut) mResnOut = 1'b1;
                    else        mHolding = 1'b1;
                end
            end
        end else if (mHolding) begin
            if (preBut) begin
                mHolding = 1'b0;
                mResnOut = 1'b1;
            end
        end else if (!preBut) begin
            mResnOut = 1'b0;
            mLowLeft = MIN_LOW;
        end
        mEdges++;
    endtask

    task automatic stepCycle(input logic butVal);
        BUT_IN = butVal;
        @(posedge CLK);
        modelEdge(butVal);
        @(negedge CLK);
        checkOutput("resnOut",  int'(RESN_OUT),  int'(mResnOut));
        checkOutput("butState", int'(BUT_STATE), int'(mBut));
        checkOutput("press",    int'(PRESS),     int'(mPress));
        checkOutput("tick",     int'(TICK),      int'((mEdges % DIV) == DIV - 1));
        if (PRESS === 1'b1) pressCount++;
    endtask

    task automatic applyStimulus(input logic level, input int cycles);
        for (int i = 0; i < cycles; i++) stepCycle(level);
    endtask

    task automatic pulseReset(input string tag);
        RESN = 1'b0;
        #1;
        checkOutput({tag, "_resnOut"},  int'(RESN_OUT),  0);
        checkOutput({tag, "_butState"}, int'(BUT_STATE), 1);
        checkOutput({tag, "_press"},    int'(PRESS),     0);
        checkOutput({tag, "_tick"},     int'(TICK),      0);
        modelReset();
        @(negedge CLK);
        @(negedge CLK);
        RESN = 1'b1;
    endtask

    initial begin
        RESN   = 1'b0;
        BUT_IN = 1'b1;
        modelReset();
        @(negedge CLK);
        pulseReset("rst");

        // Power-on interval with an idle button.
        pressCount = 0;
        applyStimulus(1'b1, 31);
        checkOutput("por_edge31", int'(RESN_OUT), 0);
        applyStimulus(1'b1, 1);
        checkOutput("por_edge32", int'(RESN_OUT), 1);
        checkOutput("por_nopress", pressCount, 0);

        // A two-tick glitch is rejected.
        applyStimulus(1'b0, 8);
        applyStimulus(1'b1, 20);
        checkOutput("glitch_butState", int'(BUT_STATE), 1);
        checkOutput("glitch_resnOut",  int'(RESN_OUT),  1);
        checkOutput("glitch_press",    pressCount, 0);

        // Short press still yields a full minimum-width pulse.
        pressCount = 0;
        applyStimulus(1'b0, 20);
        checkOutput("short_low", int'(RESN_OUT), 0);
        applyStimulus(1'b1, 60);
        checkOutput("short_recover", int'(RESN_OUT), 1);
        checkOutput("short_presses", pressCount, 1);

        // Long hold keeps RESN_OUT low until release is debounced.
        pressCount = 0;
        applyStimulus(1'b0, 200);
        checkOutput("hold_low", int'(RESN_OUT), 0);
        applyStimulus(1'b1, 40);
        checkOutput("hold_release", int'(RESN_OUT), 1);
        checkOutput("hold_presses", pressCount, 1);

        // Reset during an asserted pulse restarts the whole power-on interval.
        applyStimulus(1'b0, 16);
        checkOutput("assert_low", int'(RESN_OUT), 0);
        pulseReset("midrst");
        applyStimulus(1'b1, 31);
        checkOutput("midrst_edge31", int'(RESN_OUT), 0);
        applyStimulus(1'b1, 1);
        checkOutput("midrst_edge32", int'(RESN_OUT), 1);

        // Random button activity: mixes glitches, short presses and long holds.
        for (int seg = 0; seg < 60; seg++) begin
            int kind;
            kind = $urandom_range(0, 19);
            if (kind == 0) begin
                pulseReset("randrst");
            end else if (kind < 8) begin
                applyStimulus(1'($urandom_range(0, 1)), $urandom_range(1, 6));
            end else begin
                applyStimulus(1'($urandom_range(0, 1)), $urandom_range(8, 200));
            end
        end
        applyStimulus(1'b1, 150);
        checkOutput("final_resnOut", int'(RESN_OUT), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
